// File: rtl/hi_lo_unit.sv
// ---------------------------------------------------------------------------
// hi_lo_unit
//
// Architectural HI/LO register pair for MULT/MULTU/DIV/DIVU/MTHI/MTLO/
// MFHI/MFLO. The 64-bit multiply/divide result arrives from the ALU already
// computed. This block holds that result back for a configurable number of
// cycles, which models multi-cycle latency. While an operation is in flight
// it reports busy. Any HI/LO access during that time raises stall to the
// control FSM.
//
// Parameters
//   MULT_CYCLES  cycles from multiply start to HI/LO commit (1..15)
//   DIV_CYCLES   cycles from divide start to HI/LO commit   (1..15)
//
// Optional feature
//   HI_LO_DIV_ZERO_CHECK_EN  when defined, a divide whose divisor is zero is
//                            dropped in IDLE and div_zero pulses for one
//                            cycle. When undefined, it runs like any divide
//                            and div_zero is tied low.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   muldiv_result  ALU output: mult = {hi,lo}, div = {quotient,remainder}
//   divisor        divide operand b (zero check only)
//   mult_en        start multiply, capture muldiv_result
//   div_en         start divide, capture muldiv_result
//   mthi_en        write wdata to HI
//   mtlo_en        write wdata to LO
//   wdata          rs value for MTHI/MTLO
//   mfhi, mflo     read HI / LO
//   read_data      mfhi ? hi : (mflo ? lo : 0), combinational
//   hi, lo         current HI / LO registers
//   busy           operation in flight
//   stall          busy and any HI/LO request present
//   div_zero       one-cycle divide-by-zero pulse (optional feature)
// ---------------------------------------------------------------------------
module hi_lo_unit #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] muldiv_result,
  input  logic [31:0] divisor,
  input  logic        mult_en,
  input  logic        div_en,
  input  logic        mthi_en,
  input  logic        mtlo_en,
  input  logic [31:0] wdata,
  input  logic        mfhi,
  input  logic        mflo,
  output logic [31:0] read_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MULT_BUSY = 2'd1,
    DIV_BUSY  = 2'd2
  } state_t;

  // The counter is loaded with N-1, so the commit happens on the Nth edge
  // after the start edge.
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [63:0] pending, pending_nxt;
  logic [31:0] hi_nxt, lo_nxt;
  logic        div_zero_q, div_zero_nxt;
  logic        div_by_zero;
  logic        any_req;

`ifdef HI_LO_DIV_ZERO_CHECK_EN
  assign div_by_zero = (divisor == 32'd0);
`else
  // The zero check is compiled out, so divisor does not influence anything.
  logic unused_divisor;
  assign unused_divisor = ^divisor;
  assign div_by_zero    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      pending    <= 64'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      div_zero_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pending    <= pending_nxt;
      hi         <= hi_nxt;
      lo         <= lo_nxt;
      div_zero_q <= div_zero_nxt;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pending_nxt  = pending;
    hi_nxt       = hi;
    lo_nxt       = lo;
    div_zero_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (mult_en) begin
          pending_nxt = muldiv_result;
          cnt_nxt     = MULT_LOAD;
          state_nxt   = MULT_BUSY;
        end else if (div_en) begin
          if (div_by_zero) begin
            div_zero_nxt = 1'b1;
          end else begin
            // The ALU delivers {quotient,remainder}. MIPS puts the remainder
            // in HI and the quotient in LO, so the halves are swapped here.
            pending_nxt = {muldiv_result[31:0], muldiv_result[63:32]};
            cnt_nxt     = DIV_LOAD;
            state_nxt   = DIV_BUSY;
          end
        end else begin
          if (mthi_en) hi_nxt = wdata;
          if (mtlo_en) lo_nxt = wdata;
        end
      end
      MULT_BUSY, DIV_BUSY: begin
        // Requests are ignored here. The requester holds them under stall.
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          hi_nxt    = pending[63:32];
          lo_nxt    = pending[31:0];
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign any_req  = mfhi | mflo | mult_en | div_en | mthi_en | mtlo_en;
  assign stall    = busy & any_req;
  assign div_zero = div_zero_q;

  // Reads see only the registered values. An MTHI/MTLO issued in the same
  // cycle is not forwarded.
  always_comb begin
    read_data = 32'd0;
    if (mfhi)      read_data = hi;
    else if (mflo) read_data = lo;
  end

endmodule

// File: doc/hi_lo_unit.md
Name: hi_lo_unit

Overview:
- Downstream consumer of the ALU's 64-bit multiply/divide result.
- Holds the architectural HI/LO registers for MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- Models multi-cycle multiply/divide latency with a busy counter and raises a stall to the control FSM when a HI/LO access collides with an operation still in flight.

Parameters:
- MULT_CYCLES, 4, cycles from multiply start to HI/LO commit (legal range 1..15)
- DIV_CYCLES, 8, cycles from divide start to HI/LO commit (legal range 1..15)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- muldiv_result  in  64  ALU multiply/divide output; mult = {hi,lo}, div = {quotient,remainder}
- divisor  in  32  divide operand b, used for the zero check
- mult_en  in  1  start multiply, capture muldiv_result
- div_en  in  1  start divide, capture muldiv_result
- mthi_en  in  1  write wdata to HI
- mtlo_en  in  1  write wdata to LO
- wdata  in  32  register-file rs value for MTHI/MTLO
- mfhi  in  1  read HI
- mflo  in  1  read LO
- read_data  out  32  combinational: mfhi ? hi : (mflo ? lo : 0); HI wins if both asserted
- hi  out  32  current HI register
- lo  out  32  current LO register
- busy  out  1  operation in flight
- stall  out  1  busy & (mfhi|mflo|mult_en|div_en|mthi_en|mtlo_en)
- div_zero  out  1  one-cycle pulse, divide by zero detected (only with optional feature)

Behaviour:
- Reset (synchronous, active-high, clk edge with reset=1):
  - hi=0, lo=0, pending=0, cnt=0, state=IDLE.
  - busy=0, div_zero=0. stall and read_data derive from these and the inputs.
  - Reset during MULT_BUSY/DIV_BUSY aborts the operation; nothing is committed.
- States: IDLE, MULT_BUSY, DIV_BUSY.
- IDLE request priority (at most one acted on per edge): mult_en > div_en > (mthi_en/mtlo_en).
  - mult_en:
    - pending <= muldiv_result.
    - cnt <= MULT_CYCLES-1.
    - state -> MULT_BUSY.
  - div_en:
    - pending <= {muldiv_result[31:0], muldiv_result[63:32]}, swapped so HI = remainder and LO = quotient (MIPS convention).
    - cnt <= DIV_CYCLES-1.
    - state -> DIV_BUSY.
  - mthi_en/mtlo_en:
    - hi <= wdata and/or lo <= wdata, effective next cycle.
    - Both may be asserted together; both registers then take wdata.
- Busy states, each edge:
  - cnt != 0: cnt <= cnt-1.
  - cnt == 0: {hi,lo} <= pending, state -> IDLE.
- Timing: start sampled at edge E0 → busy=1 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES) → HI/LO updated at edge EN, busy=0 after EN.
- Any request while busy is ignored (no side effects) and raises stall. The requester holds the request until stall drops; it is then serviced in IDLE.
  - mfhi/mflo in the commit cycle (cnt==0) still stalls.
  - The next cycle returns the committed value.
- Bypass: read_data reflects registered hi/lo only; there is no forwarding of an MTHI/MTLO being written in the same cycle.
- Signedness is resolved upstream by the ALU; this block treats muldiv_result as raw bits.

Optional Feature:
- Macro: HI_LO_DIV_ZERO_CHECK_EN.
- Defined:
  - div_en in IDLE with divisor==0: no state change, HI/LO unchanged, busy stays 0.
  - div_zero pulses high for the one cycle after the sampling edge.
- Undefined:
  - The divide-by-zero case runs like any divide and commits the swapped muldiv_result.
  - div_zero is tied to 0.

Test Plan:
- Reset: hold reset 2 cycles mid-MULT_BUSY → hi=0, lo=0, busy=0, and no later commit occurs.
- MULT: mult_en 1 cycle, muldiv_result=64'h0000_0001_FFFF_FFFE (MULT_CYCLES=4) → busy high 4 cycles, then hi=32'h1, lo=32'hFFFF_FFFE.
- DIV swap: div_en, muldiv_result={32'd7,32'd3}, divisor=5 (DIV_CYCLES=8) → after 8 busy cycles lo=7, hi=3.
- Stall: mflo asserted from the cycle after mult_en → stall=1 each busy cycle; first non-stalled cycle read_data = new lo.
- MTHI/MTLO: mthi_en+mtlo_en with wdata=32'hDEAD_BEEF in IDLE → next cycle hi=lo=32'hDEAD_BEEF. Then mfhi+mflo together → read_data=hi.
- Div-zero (macro defined): div_en, divisor=0, hi=5, lo=6 → div_zero=1 one cycle, busy=0, hi=5, lo=6. Macro undefined → commit after DIV_CYCLES.
